// File: rtl/battleship_pkg.sv
// battleship_pkg: shared board geometry, fleet table and state enums
package battleship_pkg;
  localparam int GRID_W = 6;
  localparam int GRID_H = 6;
  localparam int CELLS = 36;
  localparam int NUM_SHIPS = 4;
  localparam logic [2:0] SHIP_LEN [NUM_SHIPS] = '{3'd4, 3'd3, 3'd3, 3'd2};
  localparam logic [CELLS-1:0] COL_FIRST = 36'h041041041;
  localparam logic [CELLS-1:0] COL_LAST = 36'h820820820;
  typedef enum logic {ORIENT_H, ORIENT_V} orient_t;
  typedef enum logic {ST_PLACING, ST_DONE} state_t;
endpackage

// File: rtl/ship_footprint.sv
// ship_footprint: board mask of a ship anchored at (row,col) and whether it fits; ports row, col, orient, len in; mask, fits out
import battleship_pkg::*;
module ship_footprint (
  input  logic [2:0]       row,
  input  logic [2:0]       col,
  input  orient_t          orient,
  input  logic [2:0]       len,
  output logic [CELLS-1:0] mask,
  output logic             fits
);
  always_comb begin
    mask = '0;
    for (int i = 0; i < CELLS; i++) begin
      mask[i] = orient == ORIENT_H
        ? (i / GRID_W == int'(row) && i % GRID_W >= int'(col) && i % GRID_W < int'(col) + int'(len))
        : (i % GRID_W == int'(col) && i / GRID_W >= int'(row) && i / GRID_W < int'(row) + int'(len));
    end
    fits = orient == ORIENT_H ? int'(col) + int'(len) <= GRID_W : int'(row) + int'(len) <= GRID_H;
  end
endmodule

// File: rtl/fleet_placer.sv
// fleet_placer: player-steered placement of the fleet onto the 6x6 board; ports clk, reset, up/down/left/right/rotate/place in; ships, preview, overlap, reject, ship_idx, done out; optional SHIP_SPACING_EN forbids ships touching orthogonally
import battleship_pkg::*;
module fleet_placer (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             rotate,
  input  logic             place,
  output logic [CELLS-1:0] ships,
  output logic [CELLS-1:0] preview,
  output logic             overlap,
  output logic             reject,
  output logic [2:0]       ship_idx,
  output logic             done
);
  state_t state, next_state;
  orient_t orient, rot_orient;
  logic [2:0] row, col, len;
  logic [5:0] btn, prev, rise;
  logic [CELLS-1:0] cur_mask, rot_mask;
  logic cur_fits, rot_fits, up_ok, down_ok, left_ok, right_ok, blocked, place_ok;
  assign btn = {place, rotate, up, down, left, right};
  assign rise = btn & ~prev;
  assign len = SHIP_LEN[ship_idx[1:0]];
  assign rot_orient = orient == ORIENT_H ? ORIENT_V : ORIENT_H;
  ship_footprint cur (.row(row), .col(col), .orient(orient), .len(len), .mask(cur_mask), .fits(cur_fits));
  ship_footprint rot (.row(row), .col(col), .orient(rot_orient), .len(len), .mask(rot_mask), .fits(rot_fits));
  always_comb begin
    preview = state == ST_DONE ? '0 : cur_mask;
    overlap = |(preview & ships);
    up_ok = row != 3'd0;
    left_ok = col != 3'd0;
    down_ok = (orient == ORIENT_V ? int'(row) + int'(len) : int'(row) + 1) < GRID_H;
    right_ok = (orient == ORIENT_H ? int'(col) + int'(len) : int'(col) + 1) < GRID_W;
`ifdef SHIP_SPACING_EN
    // row shifts cannot wrap; column shifts mask off cells that crossed a row edge
    blocked = overlap | |(preview & ((ships << GRID_W) | (ships >> GRID_W)
      | ((ships << 1) & ~COL_FIRST) | ((ships >> 1) & ~COL_LAST)));
`else
    blocked = overlap;
`endif
    place_ok = cur_fits && !blocked;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_PLACING;
    else state <= next_state;
  always_comb
    next_state = state == ST_PLACING && rise[5] && place_ok && ship_idx == 3'(NUM_SHIPS - 1) ? ST_DONE : state;
  always_comb
    done = state == ST_DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ships <= '0;
      ship_idx <= '0;
      row <= '0;
      col <= '0;
      orient <= ORIENT_H;
      prev <= '0;
      reject <= 1'b0;
    end else begin
      prev <= btn;
      reject <= 1'b0;
      if (state == ST_PLACING) begin
        if (rise[5]) begin
          if (place_ok) begin
            ships <= ships | preview;
            ship_idx <= ship_idx + 3'd1;
            row <= '0;
            col <= '0;
            orient <= ORIENT_H;
          end else reject <= 1'b1;
        end else if (rise[4]) begin
          if (rot_fits && |rot_mask) orient <= rot_orient;
        end else if (rise[3]) begin
          if (up_ok) row <= row - 3'd1;
        end else if (rise[2]) begin
          if (down_ok) row <= row + 3'd1;
        end else if (rise[1]) begin
          if (left_ok) col <= col - 3'd1;
        end else if (rise[0]) begin
          if (right_ok) col <= col + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fleet_placer.sv
// tb_fleet_placer: directed and random stimulus against a cell-level model of the placement rules
module tb_fleet_placer;
  localparam logic [5:0] PL = 6'b100000, RO = 6'b010000, UP = 6'b001000;
  localparam logic [5:0] DN = 6'b000100, LF = 6'b000010, RT = 6'b000001;
  logic clk = 0, reset = 1, up = 0, down = 0, left = 0, right = 0, rotate = 0, place = 0;
  logic [35:0] ships, preview;
  logic overlap, reject, done;
  logic [2:0] ship_idx;
  int checks = 0, errors = 0;
  int lens [4] = '{4, 3, 3, 2};
  int m_row, m_col, m_vert, m_idx, m_done, m_rej;
  logic [35:0] m_ships;
  logic [5:0] m_prev;
  fleet_placer dut (.clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .rotate(rotate), .place(place), .ships(ships), .preview(preview), .overlap(overlap),
    .reject(reject), .ship_idx(ship_idx), .done(done));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int on_board(int r, int c, int v, int len);
    return r >= 0 && c >= 0 && (v ? r + len <= 6 && c < 6 : c + len <= 6 && r < 6);
  endfunction
  function automatic logic [35:0] foot(int r, int c, int v, int len);
    logic [35:0] m = '0;
    for (int k = 0; k < len; k++) m[(r + k * v) * 6 + c + k * (1 - v)] = 1'b1;
    return m;
  endfunction
  function automatic int touches(logic [35:0] p, logic [35:0] s);
    int t = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        if (p[r * 6 + c])
          t |= (r > 0 && s[(r - 1) * 6 + c]) || (r < 5 && s[(r + 1) * 6 + c])
            || (c > 0 && s[r * 6 + c - 1]) || (c < 5 && s[r * 6 + c + 1]);
    return t;
  endfunction
  function automatic logic [35:0] m_preview();
    return m_done ? 36'h0 : foot(m_row, m_col, m_vert, lens[m_idx % 4]);
  endfunction
  task automatic model_reset();
    m_row = 0; m_col = 0; m_vert = 0; m_idx = 0; m_done = 0; m_rej = 0;
    m_ships = '0; m_prev = '0;
  endtask
  task automatic model_step(input logic [5:0] b);
    logic [5:0] e;
    logic [35:0] pv;
    int len, bad, nr, nc;
    e = b & ~m_prev;
    m_prev = b;
    m_rej = 0;
    if (!m_done) begin
      len = lens[m_idx];
      pv = m_preview();
      nr = m_row; nc = m_col;
      if (e[5]) begin
        bad = (pv & m_ships) != 0;
`ifdef SHIP_SPACING_EN
        bad = bad || touches(pv, m_ships);
`endif
        if (bad) m_rej = 1;
        else begin
          m_ships |= pv;
          m_idx++;
          m_row = 0; m_col = 0; m_vert = 0;
          if (m_idx == 4) m_done = 1;
        end
      end else if (e[4]) begin
        if (on_board(m_row, m_col, 1 - m_vert, len)) m_vert = 1 - m_vert;
      end else begin
        if (e[3]) nr--;
        else if (e[2]) nr++;
        else if (e[1]) nc--;
        else if (e[0]) nc++;
        if (on_board(nr, nc, m_vert, len)) begin m_row = nr; m_col = nc; end
      end
    end
  endtask
  task automatic compare_all();
    check("ships", ships, m_ships);
    check("preview", preview, m_preview());
    check("overlap", {35'd0, overlap}, {35'd0, (m_preview() & m_ships) != 0});
    check("reject", {35'd0, reject}, 36'(m_rej));
    check("ship_idx", {33'd0, ship_idx}, 36'(m_idx));
    check("done", {35'd0, done}, 36'(m_done));
  endtask
  task automatic tick(input logic [5:0] b);
    {place, rotate, up, down, left, right} = b;
    model_step(b);
    @(negedge clk);
    compare_all();
  endtask
  task automatic press(input logic [5:0] b);
    tick(b);
    tick(6'd0);
  endtask
  task automatic do_reset();
    reset = 1;
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 0;
  endtask
  initial begin
    do_reset();
    tick(6'd0);
    check("reset_preview", preview, 36'hF);
    press(PL);
    check("first_commit", ships, 36'hF);
    check("next_preview", preview, 36'h7);
    tick(PL);
    check("collide_reject", {35'd0, reject}, 36'd1);
    tick(6'd0);
    check("reject_pulse", {35'd0, reject}, 36'd0);
    press(DN);
    press(PL);
`ifndef SHIP_SPACING_EN
    check("touching_commit", ships, 36'h1CF);
`endif
    do_reset();
    repeat (4) press(RT);
    check("right_limit", preview, 36'h3C);
    repeat (3) press(DN);
    press(RO);
    check("rotate_blocked", preview, 36'hF00000);
    tick(PL | RO | DN);
    tick(6'd0);
    do_reset();
    press(PL);
    repeat (2) press(DN);
    press(PL);
    repeat (4) press(DN);
    press(PL);
    repeat (4) press(RT);
    repeat (4) press(DN);
    press(PL);
    check("fleet_done", {35'd0, done}, 36'd1);
    check("fleet_idx", {33'd0, ship_idx}, 36'd4);
    press(UP);
    press(PL);
    check("done_hold", preview, 36'h0);
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] b;
      for (int j = 0; j < 6; j++) b[j] = $urandom_range(0, 9) < 2;
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick(b);
    end
    do_reset();
    check("final_reset", ships, 36'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
